i2s_receiver: RTL and testbench

//  I2S slave receiver for the audio ADC input path. Samples external SCLK/LRCLK/SDATA
//  (64 SCLK per frame, 32-bit slots, MSB first), rebuilds 24-bit stereo samples and

---
 rtl/i2s_receiver.sv | 161 ++++++++++++++++
 tb/tb_i2s_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronizes external SCLK/LRCLK/SDATA into clk_i, rebuilds
// 24-bit left/right samples and emits one {left,right} word per frame on valid/ready.
module i2s_receiver #(
    parameter int DATA_W      = 24,
    parameter int SLOT_W      = 32,
    parameter int DELAY_BIT   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                sclk_i,
    input  logic                lrclk_i,
    input  logic                sdata_i,
    output logic [2*DATA_W-1:0] m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                overrun_o,
    output logic                sync_err_o,
    output logic                locked_o
);

    localparam int CNT_W = $clog2(SLOT_W + 9);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SLOT_W + 8);

    typedef enum logic [1:0] {S_HUNT, S_LEFT, S_RIGHT} state_t;

    state_t                   state_q;
    logic [SYNC_STAGES-1:0]   sclk_sync_q, lr_sync_q, sd_sync_q;
    logic                     sclk_prev_q, lr_prev_q, cap_done_q;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]        shreg_q;
    logic [DATA_W-1:0]        left_q, word_d;
    logic [CNT_W:0]           idx_d;
    logic                     sclk_s, lr_s, sd_s;
    logic                     strobe, slot_chg, in_data, cap, cap_last, frame_done;
    logic                     overrun_q, sync_err_q, locked_q, m_valid_q;
    logic [2*DATA_W-1:0]      m_data_q;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s   = lr_sync_q[SYNC_STAGES-1];
    assign sd_s   = sd_sync_q[SYNC_STAGES-1];

    always_comb begin
        strobe   = sclk_s & ~sclk_prev_q;
        slot_chg = lr_s != lr_prev_q;
        if (slot_chg)
            bit_cnt_d = '0;
        else if (bit_cnt_q == CNT_SAT)
            bit_cnt_d = bit_cnt_q;
        else
            bit_cnt_d = bit_cnt_q + 1'b1;
        // idx_d MSB set means the bit precedes the data (delay slot)
        idx_d      = {1'b0, bit_cnt_d} - (CNT_W+1)'(DELAY_BIT);
        in_data    = ~idx_d[CNT_W] && (idx_d[CNT_W-1:0] < CNT_W'(DATA_W));
        cap        = strobe && en_i && in_data;
        cap_last   = cap && (idx_d[CNT_W-1:0] == CNT_W'(DATA_W - 1));
        word_d     = {shreg_q, sd_s};
        frame_done = cap_last && (state_q == S_RIGHT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            cap_done_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            left_q      <= '0;
            state_q     <= S_HUNT;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk_i};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sdata_i};
            sclk_prev_q <= sclk_s;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;

            if (strobe) begin
                lr_prev_q <= lr_s;
                bit_cnt_q <= bit_cnt_d;
                if (slot_chg)
                    cap_done_q <= 1'b0;
            end
            if (cap) begin
                shreg_q <= word_d[DATA_W-2:0];
                if (cap_last)
                    cap_done_q <= 1'b1;
            end

            // cap_done_q still describes the slot that is ending on a change strobe
            if (!en_i) begin
                state_q  <= S_HUNT;
                locked_q <= 1'b0;
            end else if (strobe) begin
                case (state_q)
                    S_HUNT: begin
                        if (slot_chg && !lr_s) begin
                            state_q  <= S_LEFT;
                            locked_q <= 1'b1;
                        end
                    end
                    S_LEFT: begin
                        if (cap_last)
                            left_q <= word_d;
                        if (slot_chg && lr_s) begin
                            if (cap_done_q) begin
                                state_q <= S_RIGHT;
                            end else begin
                                state_q    <= S_HUNT;
                                locked_q   <= 1'b0;
                                sync_err_q <= 1'b1;
                            end
                        end
                    end
                    S_RIGHT: begin
                        if (slot_chg && !lr_s) begin
                            if (cap_done_q) begin
                                state_q <= S_LEFT;
                            end else begin
                                state_q    <= S_HUNT;
                                locked_q   <= 1'b0;
                                sync_err_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= S_HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            if (frame_done) begin
                if (m_valid_q && !m_ready_i) begin
                    overrun_q <= 1'b1;
                end else begin
                    m_data_q  <= {left_q, word_d};
                    m_valid_q <= 1'b1;
                end
            end else if (m_valid_q && m_ready_i) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_data_o   = m_data_q;
    assign m_valid_o  = m_valid_q;
    assign overrun_o  = overrun_q;
    assign sync_err_o = sync_err_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives I2S slots at sclk = clk/8 and checks delivered words
// against a slot-level model of lock, capture, overrun and sync-error behaviour.
`timescale 1ns/1ps
module tb_i2s_receiver;

    localparam int DW = 24;
    localparam int DB = 1;
    localparam int VALID_LEN = DB + DW;

    logic        clk = 1'b0;
    logic        rst, en, sclk, lrclk, sdata, m_ready;
    logic [47:0] m_data;
    logic        m_valid, overrun, sync_err, locked;

    i2s_receiver dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sclk_i(sclk), .lrclk_i(lrclk),
        .sdata_i(sdata), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .overrun_o(overrun), .sync_err_o(sync_err), .locked_o(locked)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef enum {M_HUNT, M_LEFT, M_RIGHT} mstate_t;
    mstate_t     m_state;
    logic        m_prev_lr;
    int          m_run_len;
    logic [23:0] m_left;
    bit          m_full;
    int          exp_ovr = 0, exp_serr = 0, got_ovr = 0, got_serr = 0;
    logic [47:0] exp_q[$];

    task automatic model_reset();
        exp_q.delete();
        m_state   = M_HUNT;
        m_prev_lr = 1'b0;
        m_run_len = 0;
        m_full    = 1'b0;
        m_left    = '0;
    endtask

    task automatic model_frame(input logic [47:0] w);
        if (!m_ready && m_full) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(w);
            if (!m_ready) m_full = 1'b1;
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        sclk = 1'b0; lrclk = lr; sdata = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input int len, input logic [23:0] w);
        bit   chg;
        logic d;
        chg = (lr != m_prev_lr);
        if (!en) begin
            m_state = M_HUNT;
        end else if (chg) begin
            case (m_state)
                M_HUNT:  if (!lr) m_state = M_LEFT;
                M_LEFT:  if (m_run_len >= VALID_LEN) m_state = M_RIGHT;
                         else begin m_state = M_HUNT; exp_serr++; end
                M_RIGHT: if (m_run_len >= VALID_LEN) m_state = M_LEFT;
                         else begin m_state = M_HUNT; exp_serr++; end
                default: m_state = M_HUNT;
            endcase
        end
        m_run_len = chg ? len : m_run_len + len;
        m_prev_lr = lr;
        if (en && chg && len >= VALID_LEN) begin
            if (m_state == M_LEFT) m_left = w;
            else if (m_state == M_RIGHT) model_frame({m_left, w});
        end
        for (int k = 0; k < len; k++) begin
            if (k >= DB && k < DB + DW) d = w[DW - 1 - (k - DB)];
            else d = 1'($urandom_range(0, 1));
            send_bit(lr, d);
        end
        check("locked", 48'(locked), 48'(m_state != M_HUNT));
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int len_l, input int len_r);
        send_slot(1'b0, len_l, l);
        send_slot(1'b1, len_r, r);
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("word_expected", 48'(exp_q.size()), 48'd1);
                else check("word", m_data, exp_q.pop_front());
            end
            if (overrun) got_ovr++;
            if (sync_err) got_serr++;
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; m_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 48'(m_valid), 48'd0);
        check("rst_data", m_data, 48'd0);
        check("rst_locked", 48'(locked), 48'd0);
        check("rst_overrun", 48'(overrun), 48'd0);
        check("rst_sync_err", 48'(sync_err), 48'd0);
        @(negedge clk);
        rst = 1'b0;

        // stream joins mid right slot, then three clean frames
        send_slot(1'b1, 12, 24'(($urandom)));
        send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 32);
        send_frame(24'h123456, 24'hABCDEF, 32, 32);
        send_frame(24'h800001, 24'h7FFFFE, 32, 32);
        repeat (20) @(negedge clk);
        check("drain_basic", 48'(exp_q.size()), 48'd0);

        // backpressure across two frames
        @(negedge clk); m_ready = 1'b0;
        send_frame(24'h111111, 24'h222222, 32, 32);
        send_frame(24'h333333, 24'h444444, 32, 32);
        repeat (10) @(negedge clk);
        #1;
        check("hold_f1", m_data, 48'h111111222222);
        check("overrun_cnt", 48'(got_ovr), 48'(exp_ovr));
        @(negedge clk); m_ready = 1'b1; m_full = 1'b0;
        send_frame(24'h555555, 24'h666666, 32, 32);
        repeat (20) @(negedge clk);
        check("drain_ovr", 48'(exp_q.size()), 48'd0);

        // truncated left slot
        send_frame(24'h0F0F0F, 24'hF0F0F0, 10, 32);
        send_frame(24'hC3C3C3, 24'h3C3C3C, 32, 32);
        repeat (20) @(negedge clk);
        check("sync_err_cnt", 48'(got_serr), 48'(exp_serr));
        check("drain_serr", 48'(exp_q.size()), 48'd0);

        // async reset with a word pending and mid-slot
        @(negedge clk); m_ready = 1'b0;
        send_frame(24'h777777, 24'h888888, 32, 32);
        send_slot(1'b0, 15, 24'h999999);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 48'(m_valid), 48'd0);
        check("mid_rst_data", m_data, 48'd0);
        check("mid_rst_locked", 48'(locked), 48'd0);
        model_reset();
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_slot(1'b0, 17, 24'(($urandom)));
        send_slot(1'b1, 32, 24'(($urandom)));
        send_frame(24'(($urandom)), 24'(($urandom)), 32, 32);
        repeat (20) @(negedge clk);
        check("drain_rst", 48'(exp_q.size()), 48'd0);

        // receiver disabled for one frame
        @(negedge clk); en = 1'b0;
        send_frame(24'(($urandom)), 24'(($urandom)), 32, 32);
        @(negedge clk); en = 1'b1;
        send_frame(24'(($urandom)), 24'(($urandom)), 32, 32);
        send_frame(24'(($urandom)), 24'(($urandom)), 32, 32);

        // random words, occasional short or overlong slots
        for (int f = 0; f < 20; f++) begin
            int ll, lr;
            ll = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 48)) : 32;
            lr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 48)) : 32;
            send_frame(24'(($urandom)), 24'(($urandom)), ll, lr);
        end
        send_slot(1'b0, 32, 24'(($urandom)));
        repeat (20) @(negedge clk);
        check("drain_final", 48'(exp_q.size()), 48'd0);
        check("overrun_final", 48'(got_ovr), 48'(exp_ovr));
        check("sync_err_final", 48'(got_serr), 48'(exp_serr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
